// File: rtl/disp_slave_multi.sv
// Write-only serial-bus slave driving NUM_CH banks of NUM_DIGITS 7-segment digits.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module disp_slave_multi #(
    parameter int                  ADDRESS_WIDTH = 15,
    parameter int                  DATA_WIDTH    = 8,
    parameter int                  ID_WIDTH      = 2,
    parameter logic [ID_WIDTH-1:0] SELF_ID       = {ID_WIDTH{1'b0}},
    parameter int                  NUM_CH        = 2,
    parameter int                  NUM_DIGITS    = 3
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           bus_util,
    inout  wire                            data_bus_serial,
    output logic                           busy_out,
    output logic [NUM_CH*NUM_DIGITS*7-1:0] dout
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int BANK_W  = 7 * NUM_DIGITS;
    localparam int DOUT_W  = NUM_CH * BANK_W;
    localparam int CNT_MAX = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDRESS_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CONV_END  = CNT_W'(DATA_WIDTH);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_ACK  = 3'd3,
        S_CONV = 3'd4,
        S_SKIP = 3'd5
    } state_t;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Walks digits from the most significant so leading zeros can be recognised.
    function automatic logic [BANK_W-1:0] encode_bank(input logic [BCD_W-1:0] bcd,
                                                      input logic             ovf);
        logic       lead;
        logic [3:0] nib;
        encode_bank = {BANK_W{1'b1}};
        lead        = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            nib = bcd[d*4 +: 4];
            if (ovf) begin
                encode_bank[d*7 +: 7] = SEG_DASH;
            end else if (BLANK_EN && lead && (nib == 4'd0) && (d != 0)) begin
                encode_bank[d*7 +: 7] = SEG_BLANK;
            end else begin
                encode_bank[d*7 +: 7] = seg7(nib);
            end
            lead = lead && (nib == 4'd0);
        end
    endfunction

    localparam logic [DOUT_W-1:0] RESET_DOUT = {NUM_CH{encode_bank({BCD_W{1'b0}}, 1'b0)}};

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [ADDRESS_WIDTH-2:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [BCD_W-1:0]         bcd_q;
    logic                     ovf_q;
    logic [CH_W-1:0]          ch_q;
    logic                     busy_q;
    logic                     ack_q;
    logic [DOUT_W-1:0]        dout_q;

    logic                     line_s;
    logic [ADDRESS_WIDTH-1:0] addr_full_s;
    logic                     match_s;
    logic [BCD_W-1:0]         bcd_adj_s;
    logic [BCD_W-1:0]         bcd_step_s;
    logic                     carry_s;

    assign line_s          = data_bus_serial;
    assign data_bus_serial = (ack_q && bus_util) ? 1'b1 : 1'bz;
    assign busy_out        = busy_q;
    assign dout            = dout_q;

    // Address decode on the bit currently on the line so the decision lands on the last edge.
    always_comb begin
        addr_full_s = {addr_q, line_s};
        match_s     = (addr_full_s[ADDRESS_WIDTH-1 -: ID_WIDTH] == SELF_ID) &&
                      (int'(addr_full_s[CH_W-1:0]) < NUM_CH);
    end

    // One double-dabble step; a bit leaving the top nibble means the value does not fit.
    always_comb begin
        bcd_adj_s = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj_s[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end else begin
                bcd_adj_s[i*4 +: 4] = bcd_q[i*4 +: 4];
            end
        end
        bcd_step_s = {bcd_adj_s[BCD_W-2:0], data_q[DATA_WIDTH-1]};
        carry_s    = bcd_adj_s[BCD_W-1];
    end

    // Frame reception, conversion and display latch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            addr_q  <= {(ADDRESS_WIDTH-1){1'b0}};
            data_q  <= {DATA_WIDTH{1'b0}};
            bcd_q   <= {BCD_W{1'b0}};
            ovf_q   <= 1'b0;
            ch_q    <= {CH_W{1'b0}};
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            dout_q  <= RESET_DOUT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus_util && (line_s == 1'b1)) begin
                        state_q <= S_ADDR;
                        busy_q  <= 1'b1;
                        cnt_q   <= {CNT_W{1'b0}};
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    if (!bus_util) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        addr_q <= addr_full_s[ADDRESS_WIDTH-2:0];
                        if (cnt_q == ADDR_LAST) begin
                            cnt_q <= {CNT_W{1'b0}};
                            ch_q  <= addr_full_s[CH_W-1:0];
                            if (match_s) begin
                                state_q <= S_DATA;
                            end else begin
                                state_q <= S_SKIP;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (!bus_util) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        data_q <= {data_q[DATA_WIDTH-2:0], line_s};
                        if (cnt_q == DATA_LAST) begin
                            cnt_q   <= {CNT_W{1'b0}};
                            state_q <= S_ACK;
                            ack_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_ACK: begin
                    ack_q <= 1'b0;
                    if (!bus_util) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_CONV;
                        bcd_q   <= {BCD_W{1'b0}};
                        ovf_q   <= 1'b0;
                        cnt_q   <= {CNT_W{1'b0}};
                    end
                end
                S_CONV: begin
                    // Once acknowledged the frame always completes, whatever bus_util does.
                    if (cnt_q == CONV_END) begin
                        dout_q[int'(ch_q)*BANK_W +: BANK_W] <= encode_bank(bcd_q, ovf_q);
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        bcd_q  <= bcd_step_s;
                        ovf_q  <= ovf_q | carry_s;
                        data_q <= {data_q[DATA_WIDTH-2:0], 1'b0};
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                S_SKIP: begin
                    if (!bus_util) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_SKIP;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_slave_multi.sv
// Self-checking bench for disp_slave_multi: directed frames followed by random frames
// checked against an arithmetic model of the displayed digits.
module tb_disp_slave_multi;

    localparam int AW     = 15;
    localparam int DW     = 8;
    localparam int NC     = 2;
    localparam int ND     = 3;
    localparam int BANK_W = ND * 7;
    localparam int DOW    = NC * BANK_W;

    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic           clk = 1'b0;
    logic           rstn;
    logic           bus_util;
    logic           drv_en;
    logic           drv_val;
    wire            line;
    logic           busy_out;
    logic [DOW-1:0] dout;

    int tests = 0;
    int fails = 0;

    logic [BANK_W-1:0] bank_exp [NC];

    assign line = drv_en ? drv_val : 1'bz;

    always #5 clk = ~clk;

    disp_slave_multi #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(2), .SELF_ID(2'b00),
        .NUM_CH(NC), .NUM_DIGITS(ND)
    ) dut (
        .clk(clk), .rstn(rstn), .bus_util(bus_util), .data_bus_serial(line),
        .busy_out(busy_out), .dout(dout)
    );

    // Decimal digits of v, least significant first, as the display should show them.
    function automatic logic [BANK_W-1:0] model_bank(input int v);
        int p;
        logic [6:0] seg;
        model_bank = '0;
        p = 1;
        for (int d = 0; d < ND; d++) begin
            if (v > (10 ** ND) - 1) begin
                seg = 7'b0111111;
            end else begin
                seg = SEG_TAB[(v / p) % 10];
`ifdef LEADING_ZERO_BLANK_EN
                if (d > 0 && v < p) seg = 7'b1111111;
`endif
            end
            model_bank[d*7 +: 7] = seg;
            p = p * 10;
        end
    endfunction

    function automatic logic [DOW-1:0] exp_dout();
        exp_dout = '0;
        for (int c = 0; c < NC; c++) exp_dout[c*BANK_W +: BANK_W] = bank_exp[c];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int c = 0; c < NC; c++) bank_exp[c] = model_bank(0);
    endtask

    // abort_at >= 0 drops bus_util after that many data bits; do_rst pulses rstn mid-conversion.
    task automatic send_frame(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input int abort_at, input bit do_rst);
        bit acc;
        int ch;
        acc = (addr[AW-1 -: 2] == 2'b00) && (int'(addr[0]) < NC);
        ch  = int'(addr[0]);
        bus_util = 1'b1;
        drv_en   = 1'b1;
        drv_val  = 1'b1;
        tick();
        check("busy_after_start", busy_out, 1);
        for (int i = AW - 1; i >= 0; i--) begin
            drv_val = addr[i];
            tick();
        end
        if (!acc) check("skip_busy", busy_out, 0);
        for (int i = DW - 1; i >= 0; i--) begin
            if (abort_at == DW - 1 - i) begin
                bus_util = 1'b0;
                drv_en   = 1'b0;
                tick();
                check("abort_busy", busy_out, 0);
                check("abort_line", line === 1'b1, 0);
                check("abort_dout", dout, exp_dout());
                tick();
                return;
            end
            drv_val = data[i];
            tick();
        end
        drv_en = 1'b0;
        #1;
        check(acc ? "ack_drive" : "skip_no_drive", line === 1'b1, acc);
        tick();
        check("line_released", line === 1'b1, 0);
        bus_util = 1'b0;
        if (!acc) begin
            tick();
            check("skip_dout", dout, exp_dout());
            check("skip_idle_busy", busy_out, 0);
            return;
        end
        if (do_rst) begin
            repeat (3) tick();
            rstn = 1'b0;
            #2;
            reset_model();
            check("rst_busy", busy_out, 0);
            check("rst_line", line === 1'b1, 0);
            check("rst_dout", dout, exp_dout());
            rstn = 1'b1;
            tick();
            return;
        end
        repeat (8) tick();
        check("conv_hold_dout", dout, exp_dout());
        check("conv_busy", busy_out, 1);
        tick();
        bank_exp[ch] = model_bank(int'(data));
        check("update_dout", dout, exp_dout());
        check("update_busy", busy_out, 0);
        tick();
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [1:0]    id;
        int            ab;
        rstn     = 1'b0;
        bus_util = 1'b0;
        drv_en   = 1'b0;
        drv_val  = 1'b0;
        reset_model();
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check("reset_busy", busy_out, 0);
        check("reset_line", line === 1'b1, 0);
        check("reset_dout", dout, exp_dout());

        send_frame(15'h0000, 8'd123, -1, 1'b0);
        send_frame(15'h2000, 8'd77, -1, 1'b0);
        send_frame(15'h0001, 8'd255, -1, 1'b0);
        send_frame(15'h0000, 8'd42, 4, 1'b0);
        send_frame(15'h0000, 8'd7, -1, 1'b0);
        send_frame(15'h0001, 8'd0, -1, 1'b0);
        send_frame(15'h0001, 8'd200, -1, 1'b1);
        send_frame(15'h0001, 8'd99, -1, 1'b0);

        for (int n = 0; n < 24; n++) begin
            id = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            a  = {id, 12'($urandom), 1'($urandom)};
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DW - 1)) : -1;
            send_frame(a, 8'($urandom), ab, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
